// File: rtl/seg7_count_display.sv
// seg7_count_display: shows an 8-bit binary value in decimal on a 4-digit
// multiplexed 7-segment display. A multi-cycle double-dabble FSM converts the
// value to 3-digit BCD, and a refresh divider scans the digits right to left.
//
// Conversion FSM states:
//   state | meaning
//   IDLE  | waiting for value to differ from the last converted value
//   SHIFT | 8 double-dabble steps, one input bit per clock
//   LATCH | publish the work BCD and remember which value it belongs to
module seg7_count_display #(
  parameter int REFRESH_DIV    = 100_000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int BLANK_LEADING  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  value,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [3:0]  an,
  output logic [11:0] bcd,
  output logic        busy
);

  localparam int              CNT_W   = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(REFRESH_DIV - 1);
  localparam logic [6:0]      SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic            DP_OFF  = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    LATCH = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  shift_reg;
  logic [7:0]  cap_value;
  logic [7:0]  last_value;
  logic [11:0] work;
  logic [2:0]  bit_cnt;

  logic [11:0] work_adj;
  logic [19:0] dabble_shifted;

  logic [CNT_W-1:0] refresh_cnt;
  logic [1:0]       digit_sel;

  logic [3:0] nibble;
  logic       blank;
  logic [6:0] seg_hi;
  logic [3:0] an_next;
  logic [6:0] seg_next;

  // Active-high gfedcba pattern; anything above 9 stays dark.
  function automatic logic [6:0] decode(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'h3F;
      4'd1:    p = 7'h06;
      4'd2:    p = 7'h5B;
      4'd3:    p = 7'h4F;
      4'd4:    p = 7'h66;
      4'd5:    p = 7'h6D;
      4'd6:    p = 7'h7D;
      4'd7:    p = 7'h07;
      4'd8:    p = 7'h7F;
      4'd9:    p = 7'h6F;
      default: p = 7'h00;
    endcase
    return p;
  endfunction

  // Add 3 to every BCD nibble that is 5 or more, ahead of the shift.
  function automatic logic [11:0] dabble_adjust(input logic [11:0] w);
    logic [11:0] r;
    r = w;
    for (int i = 0; i < 3; i++) begin
      if (w[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = w[i*4 +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  assign work_adj       = dabble_adjust(work);
  assign dabble_shifted = {work_adj, shift_reg} << 1;
  assign busy           = (state != IDLE);

  // Conversion FSM: capture on change, 8 shift steps, then latch the result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      shift_reg  <= 8'd0;
      cap_value  <= 8'd0;
      last_value <= 8'd0;
      work       <= 12'd0;
      bit_cnt    <= 3'd0;
      bcd        <= 12'h000;
    end else begin
      case (state)
        IDLE: begin
          if (value != last_value) begin
            shift_reg <= value;
            cap_value <= value;
            work      <= 12'd0;
            bit_cnt   <= 3'd0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          work      <= dabble_shifted[19:8];
          shift_reg <= dabble_shifted[7:0];
          bit_cnt   <= bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) begin
            state <= LATCH;
          end
        end
        LATCH: begin
          bcd        <= work;
          last_value <= cap_value;
          state      <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Refresh divider: advance to the next digit slot every REFRESH_DIV clocks.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      refresh_cnt <= '0;
      digit_sel   <= 2'd0;
    end else if (refresh_cnt == CNT_MAX) begin
      refresh_cnt <= '0;
      digit_sel   <= digit_sel + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Pick the digit for the current slot and decide whether it is blanked.
  always_comb begin
    nibble = 4'd0;
    blank  = 1'b1;
    case (digit_sel)
      2'd0: begin
        nibble = bcd[3:0];
        blank  = 1'b0;
      end
      2'd1: begin
        nibble = bcd[7:4];
        blank  = (BLANK_LEADING != 0) && (bcd[11:4] == 8'h00);
      end
      2'd2: begin
        nibble = bcd[11:8];
        blank  = (BLANK_LEADING != 0) && (bcd[11:8] == 4'h0);
      end
      default: begin
        nibble = 4'd0;
        blank  = 1'b1;
      end
    endcase
    seg_hi = decode(nibble);
    if (blank) begin
      an_next  = 4'b1111;
      seg_next = SEG_OFF;
    end else begin
      an_next  = ~(4'b0001 << digit_sel);
      seg_next = (SEG_ACTIVE_LOW != 0) ? ~seg_hi : seg_hi;
    end
  end

  // Register the display drive so the pins change cleanly once per clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= 4'b1111;
      seg <= SEG_OFF;
      dp  <= DP_OFF;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= DP_OFF;
    end
  end

endmodule

// File: tb/tb_seg7_count_display.sv
// Testbench for seg7_count_display with a fast refresh divider. A reference
// model computes BCD with division and the scan slot from the edge count.
module tb_seg7_count_display;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  value;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic [11:0] bcd;
  logic        busy;

  int checks = 0;
  int errors = 0;

  seg7_count_display #(
    .REFRESH_DIV(DIV),
    .SEG_ACTIVE_LOW(1),
    .BLANK_LEADING(1)
  ) dut (
    .clk(clk),
    .reset(reset),
    .value(value),
    .seg(seg),
    .dp(dp),
    .an(an),
    .bcd(bcd),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  value;
    logic [11:0] bcd;
  } vec_t;

  vec_t vecs[9];

  logic [6:0] seg_tab[10];

  // reference model state
  int         m_left;
  logic [7:0] m_last;
  logic [7:0] m_cap;
  logic [11:0] m_bcd;
  int         m_edges;
  logic [3:0] m_an;
  logic [6:0] m_seg;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_left  = 0;
    m_last  = 8'd0;
    m_cap   = 8'd0;
    m_bcd   = 12'h000;
    m_edges = 0;
    m_an    = 4'hF;
    m_seg   = 7'h7F;
  endtask

  task automatic model_display(input int sel, input logic [11:0] b);
    int d;
    bit lit;
    d   = 0;
    lit = 1'b0;
    case (sel)
      0: begin d = b[3:0];  lit = 1'b1; end
      1: begin d = b[7:4];  lit = (b[11:4] != 8'h00); end
      2: begin d = b[11:8]; lit = (b[11:8] != 4'h0); end
      default: lit = 1'b0;
    endcase
    if (lit) begin
      m_an  = ~(4'b0001 << sel);
      m_seg = ~seg_tab[d];
    end else begin
      m_an  = 4'hF;
      m_seg = 7'h7F;
    end
  endtask

  task automatic model_edge();
    model_display((m_edges / DIV) % 4, m_bcd);
    m_edges++;
    if (m_left == 0) begin
      if (value != m_last) begin
        m_cap  = value;
        m_left = 9;
      end
    end else begin
      m_left--;
      if (m_left == 0) begin
        m_bcd  = to_bcd(m_cap);
        m_last = m_cap;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'(m_left != 0));
    check({tag, "_bcd"},  32'(bcd),  32'(m_bcd));
    check({tag, "_an"},   32'(an),   32'(m_an));
    check({tag, "_seg"},  32'(seg),  32'(m_seg));
    check({tag, "_dp"},   32'(dp),   32'h1);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      if (!reset) model_reset();
      else model_edge();
      #1;
      check_outputs("cyc");
    end
  endtask

  // Start a conversion from IDLE and confirm bcd only moves at edge N+9.
  task automatic convert_check(input logic [7:0] v, input logic [11:0] exp);
    logic [11:0] old;
    old   = m_bcd;
    value = v;
    step(1);
    check("conv_busy_start", 32'(busy), 32'h1);
    repeat (8) begin
      step(1);
      check("conv_bcd_hold", 32'(bcd), 32'(old));
      check("conv_busy_mid", 32'(busy), 32'h1);
    end
    step(1);
    check("conv_bcd_done", 32'(bcd), 32'(exp));
    check("conv_busy_end", 32'(busy), 32'h0);
  endtask

  initial begin
    seg_tab[0] = 7'h3F; seg_tab[1] = 7'h06; seg_tab[2] = 7'h5B; seg_tab[3] = 7'h4F;
    seg_tab[4] = 7'h66; seg_tab[5] = 7'h6D; seg_tab[6] = 7'h7D; seg_tab[7] = 7'h07;
    seg_tab[8] = 7'h7F; seg_tab[9] = 7'h6F;

    vecs[0] = '{8'd1,   12'h001};
    vecs[1] = '{8'd9,   12'h009};
    vecs[2] = '{8'd10,  12'h010};
    vecs[3] = '{8'd99,  12'h099};
    vecs[4] = '{8'd100, 12'h100};
    vecs[5] = '{8'd199, 12'h199};
    vecs[6] = '{8'd255, 12'h255};
    vecs[7] = '{8'd0,   12'h000};
    vecs[8] = '{8'd128, 12'h128};

    // reset held with a nonzero value on the input
    reset = 1'b0;
    value = 8'd200;
    model_reset();
    step(3);
    check("rst_an",  32'(an),   32'hF);
    check("rst_seg", 32'(seg),  32'h7F);
    check("rst_bcd", 32'(bcd),  32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    reset = 1'b1;
    convert_check(8'd200, 12'h200);
    step(20);

    // 0 then 255 from IDLE
    convert_check(8'd0, 12'h000);
    convert_check(8'd255, 12'h255);
    step(4);

    // single digit 7, full frames
    convert_check(8'd7, 12'h007);
    step(32);

    // 105: zero tens digit stays visible
    convert_check(8'd105, 12'h105);
    step(32);

    // value change during SHIFT is deferred to a second conversion
    value = 8'd12;
    step(1);
    step(3);
    value = 8'd200;
    step(6);
    check("mid_bcd_first", 32'(bcd), 32'h012);
    check("mid_busy_gap", 32'(busy), 32'h0);
    step(1);
    check("mid_busy_restart", 32'(busy), 32'h1);
    step(9);
    check("mid_bcd_second", 32'(bcd), 32'h200);
    step(8);

    // table of values with their decimal forms
    for (int i = 0; i < 9; i++) begin
      value = vecs[i].value;
      step(12);
      check("vec_bcd", 32'(bcd), 32'(vecs[i].bcd));
      check("vec_busy", 32'(busy), 32'h0);
      step(16);
    end

    // random values held for random spans, including mid-conversion changes
    for (int i = 0; i < 40; i++) begin
      value = 8'($urandom_range(0, 255));
      step($urandom_range(1, 14));
    end
    step(12);

    // reset in the middle of a conversion
    value = (m_last == 8'd50) ? 8'd51 : 8'd50;
    step(4);
    reset = 1'b0;
    #1;
    model_reset();
    check_outputs("rst_mid");
    value = 8'd9;
    step(2);
    reset = 1'b1;
    step(12);
    check("post_rst_bcd", 32'(bcd), 32'h009);
    step(16);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
